// File: rtl/uart_reg_bridge.sv
// 8N1 UART to register-bus bridge: command byte, optional data byte,
// single-cycle write strobe and read-back of one byte over TX.
module uart_reg_bridge #(
  parameter int UART_CLK_FREQ = 24_000_000,
  parameter int UART_BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] rdata,
  output logic [7:0] wdata,
  output logic [6:0] addr,
  output logic       write,
  output logic       read_ack
);

  localparam int DIV = UART_CLK_FREQ / UART_BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    CMD, WDATA, RD_WAIT
  } cmd_state_t;

  logic rx_m, rx_s, rx_p;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= uart_rxd;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  rx_state_t     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_valid, rx_ferr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + CW'(1);
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_p && !rx_s) rx_st_n = RX_START;
      end
      RX_START: begin
        // mid-bit recheck rejects short glitches
        if (rx_cnt == MID) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          rx_valid = rx_s;
          rx_ferr  = !rx_s;
        end
      end
    endcase
  end

  cmd_state_t cmd_st, cmd_st_n;
  tx_state_t  tx_st, tx_st_n;
  logic [6:0] addr_n;
  logic [7:0] wdata_n;
  logic       write_n, read_ack_n;
  logic       tx_idle, capture;

  // read_ack marks the capture cycle, so TX counts busy from there on
  assign tx_idle = (tx_st == TX_IDLE) && !read_ack;
  assign capture = (cmd_st == RD_WAIT) && tx_idle;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cmd_st   <= CMD;
      addr     <= '0;
      wdata    <= '0;
      write    <= 1'b0;
      read_ack <= 1'b0;
    end else begin
      cmd_st   <= cmd_st_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      write    <= write_n;
      read_ack <= read_ack_n;
    end
  end

  always_comb begin
    cmd_st_n   = cmd_st;
    addr_n     = addr;
    wdata_n    = wdata;
    write_n    = 1'b0;
    read_ack_n = 1'b0;
    unique case (cmd_st)
      CMD: begin
        if (rx_valid) begin
          addr_n   = rx_sh[6:0];
          cmd_st_n = rx_sh[7] ? WDATA : RD_WAIT;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          wdata_n  = rx_sh;
          write_n  = 1'b1;
          cmd_st_n = CMD;
        end else if (rx_ferr) begin
          cmd_st_n = CMD;
        end
      end
      RD_WAIT: begin
        if (capture) begin
          read_ack_n = 1'b1;
          cmd_st_n   = CMD;
        end else if (rx_ferr) begin
          cmd_st_n = CMD;
        end
      end
      default: cmd_st_n = CMD;
    endcase
  end

  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n, tx_nb;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          txd_n;

  assign tx_nb = tx_bit + 3'd1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx_st    <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_st    <= tx_st_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      uart_txd <= txd_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = capture ? rdata : tx_sh;
    txd_n    = uart_txd;
    unique case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (read_ack) begin
          tx_st_n = TX_START;
          txd_n   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = TX_DATA;
          txd_n    = tx_sh[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_st_n = TX_STOP;
            txd_n   = 1'b1;
          end else begin
            tx_bit_n = tx_nb;
            txd_n    = tx_sh[tx_nb];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_st_n  = TX_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge at DIV=16: vector table plus hand sequences,
// with queue scoreboards for writes, read acks and TX frames.
module tb_uart_reg_bridge;

  localparam int DIV = 16;

  logic       clk;
  logic       n_reset;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic [6:0] addr;
  logic       write;
  logic       read_ack;

  uart_reg_bridge #(
    .UART_CLK_FREQ(16),
    .UART_BAUD(1)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .rdata(rdata),
    .wdata(wdata),
    .addr(addr),
    .write(write),
    .read_ack(read_ack)
  );

  // register-file stand-in: rdata is a fixed function of addr
  assign rdata = 8'h7C ^ {1'b0, addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  typedef struct {
    int c;
    bit exact;
  } rd_t;

  typedef struct {
    bit         wr;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [6:0] exp_addr;
    logic [7:0] exp_tx;
  } vec_t;

  wr_t        exp_wr[$];
  rd_t        exp_rd[$];
  logic [7:0] exp_tx[$];

  int checks = 0;
  int failures = 0;
  int busy_until = 0;
  int last_ack = -100;
  bit rst_seen = 0;
  logic [6:0] cur_addr = 7'h00;
  logic [7:0] cur_wdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop,
                           input bit chk_en, input logic [6:0] a_old,
                           input logic [6:0] a_new);
    logic [7:0] sh;
    sh = b;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) uart_rxd = 1'b0;
      else if (k == 9) uart_rxd = stop;
      else begin
        uart_rxd = sh[0];
        sh = sh >> 1;
      end
      for (int i = 0; i < DIV; i++) begin
        @(negedge clk);
        if (chk_en && k == 9 && i == 10)
          chk("addr_at_n", 32'(addr), 32'(a_old));
        if (chk_en && k == 9 && i == 11)
          chk("addr_at_n1", 32'(addr), 32'(a_new));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0
           && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL idle_timeout pending wr=%0d rd=%0d tx=%0d",
               exp_wr.size(), exp_rd.size(), exp_tx.size());
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    t = cyc;
    if (v.wr) begin
      send_byte(v.cmd, 1'b1, 1'b1, cur_addr, v.exp_addr);
      t = cyc;
      exp_wr.push_back('{v.exp_addr, v.dat, t + 155});
      send_byte(v.dat, 1'b1, 1'b1, v.exp_addr, v.exp_addr);
      cur_wdata = v.dat;
    end else begin
      exp_rd.push_back('{t + 156, 1'b1});
      exp_tx.push_back(v.exp_tx);
      send_byte(v.cmd, 1'b1, 1'b1, cur_addr, v.exp_addr);
    end
    cur_addr = v.exp_addr;
    wait_idle();
    chk("addr_after", 32'(addr), 32'(v.exp_addr));
    chk("wdata_after", 32'(wdata), 32'(cur_wdata));
  endtask

  always @(negedge n_reset) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (write) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h wdata=%h cyc=%0d",
                 addr, wdata, cyc);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(addr), 32'(w.a));
        chk("wr_data", 32'(wdata), 32'(w.d));
        chk("wr_cycle", cyc, w.c);
      end
      chk("wr_no_ack", 32'(read_ack), 32'h0);
    end
  end

  always @(negedge clk) begin
    if (read_ack) begin
      last_ack = cyc;
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read_ack cyc=%0d", cyc);
      end else begin
        rd_t r;
        r = exp_rd.pop_front();
        if (r.exact) chk("ack_cycle", cyc, r.c);
        else begin
          checks++;
          if (cyc < busy_until || cyc > busy_until + 2) begin
            failures++;
            $display("FAIL ack_wait actual=%0d required=%0d..%0d",
                     cyc, busy_until, busy_until + 2);
          end
        end
      end
    end
  end

  initial begin
    int s;
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && uart_txd === 1'b0) begin
        s = cyc;
        rst_seen = 1'b0;
        chk("tx_gap", 32'(s >= busy_until), 32'h1);
        chk("tx_after_ack", s - 1, last_ack);
        busy_until = s + 10 * DIV;
        repeat (DIV / 2) @(negedge clk);
        st = uart_txd;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        sp = uart_txd;
        if (!rst_seen) begin
          chk("tx_start", 32'(st), 32'h0);
          chk("tx_stop", 32'(sp), 32'h1);
          if (exp_tx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx_frame byte=%h", b);
          end else begin
            chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    failures++;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int t;
    vec_t v;
    vecs[0] = '{1'b1, 8'hA1, 8'h5C, 7'h21, 8'h00};
    vecs[1] = '{1'b0, 8'h40, 8'h00, 7'h40, 8'h3C};
    vecs[2] = '{1'b1, 8'hFF, 8'hA5, 7'h7F, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 7'h00, 8'h7C};
    vecs[4] = '{1'b1, 8'h80, 8'h81, 7'h00, 8'h00};
    vecs[5] = '{1'b0, 8'h7F, 8'h00, 7'h7F, 8'h03};

    uart_rxd = 1'b1;
    n_reset = 1'b0;
    #12;
    chk("rst_txd", 32'(uart_txd), 32'h1);
    chk("rst_wdata", 32'(wdata), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_read_ack", 32'(read_ack), 32'h0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-to-back reads: second waits for the first frame to finish
    t = cyc;
    exp_rd.push_back('{t + 156, 1'b1});
    exp_tx.push_back(8'h3C);
    send_byte(8'h40, 1'b1, 1'b1, cur_addr, 7'h40);
    exp_rd.push_back('{0, 1'b0});
    exp_tx.push_back(8'h3D);
    send_byte(8'h41, 1'b1, 1'b1, 7'h40, 7'h41);
    cur_addr = 7'h41;
    wait_idle();
    chk("b2b_addr", 32'(addr), 32'h41);

    // short low glitch
    uart_rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("glitch_addr", 32'(addr), 32'(cur_addr));
    chk("glitch_wdata", 32'(wdata), 32'(cur_wdata));

    // framing error on the data byte of a write
    send_byte(8'hA2, 1'b1, 1'b1, cur_addr, 7'h22);
    cur_addr = 7'h22;
    send_byte(8'h77, 1'b0, 1'b1, 7'h22, 7'h22);
    uart_rxd = 1'b1;
    wait_idle();
    chk("ferr_wdata", 32'(wdata), 32'(cur_wdata));
    v = '{1'b0, 8'h30, 8'h00, 7'h30, 8'h4C};
    run_vec(v);

    // reset during TX data bit 4 of a 0x2C frame
    t = cyc;
    exp_rd.push_back('{t + 156, 1'b1});
    send_byte(8'h50, 1'b1, 1'b1, cur_addr, 7'h50);
    repeat (84) @(posedge clk);
    #1;
    chk("pre_rst_txd", 32'(uart_txd), 32'h0);
    chk("pre_rst_wdata", 32'(wdata), 32'(cur_wdata));
    #1;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_txd", 32'(uart_txd), 32'h1);
    chk("mid_rst_addr", 32'(addr), 32'h0);
    chk("mid_rst_wdata", 32'(wdata), 32'h0);
    chk("mid_rst_write", 32'(write), 32'h0);
    chk("mid_rst_ack", 32'(read_ack), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rst_txd", 32'(uart_txd), 32'h1);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    cur_addr = 7'h00;
    cur_wdata = 8'h00;
    v = '{1'b1, 8'hA0, 8'h01, 7'h20, 8'h00};
    run_vec(v);
    chk("final_txd", 32'(uart_txd), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Serial front end of the SCA target: converts 8N1 UART traffic from the host into single-cycle register-bus accesses (addr/wdata/write) and returns register read data (rdata) over UART.
- Sits directly upstream of the register file and control logic that loads plaintext, key, tweaks and randomness into the masked SKINNY core and reads back the ciphertext bytes.
- Protocol per access: a command byte (bit7=1 write, bit7=0 read; bits 6:0 = address). A write is followed by one data byte. A read is answered by one byte on TX.

Parameters:
- UART_CLK_FREQ, 24_000_000, clk frequency in Hz.
- UART_BAUD, 115_200, baud rate. DIV = UART_CLK_FREQ/UART_BAUD, integer truncation (208 at the defaults). DIV must be >= 4.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- n_reset  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input, asynchronous to clk, idle high.
- uart_txd  out  1  serial output, idle high.
- rdata  in  8  read data from the register file, combinational from addr.
- wdata  out  8  write data, held until the next write.
- addr  out  7  register address, held stable until the next command byte.
- write  out  1  one-cycle write strobe.
- read_ack  out  1  one-cycle pulse when rdata is captured for TX.

Behaviour:
- Reset values: uart_txd=1, wdata=0, addr=0, write=0, read_ack=0. All FSMs go to IDLE and the synchronizer flops go to 1.
- Reset is async assert. Asserting reset mid-frame aborts any RX or TX immediately; uart_txd=1 in the same cycle.
- RX path:
  - uart_rxd passes through a 2-flop synchronizer.
  - RX_IDLE: a synced falling edge starts a bit counter.
  - At DIV/2 the start bit is rechecked. If it reads high (glitch), go back to RX_IDLE with no byte.
  - Data bits are sampled every DIV cycles, LSB first, followed by the stop bit.
  - If the stop bit is 1, rx_valid pulses for 1 cycle (cycle N) with the byte.
  - If the stop bit is 0 (framing error), the byte is discarded and the command FSM is forced to CMD.
  - RX re-arms in the cycle after the stop-bit sample.
- Command FSM states: CMD, WDATA, RD_WAIT.
  - CMD + rx_valid, bit7=1: addr <= byte[6:0] at N+1; go to WDATA.
  - CMD + rx_valid, bit7=0: addr <= byte[6:0] at N+1; go to RD_WAIT.
  - WDATA + rx_valid: wdata <= byte and write=1 for exactly cycle N+1; go to CMD. addr is unchanged.
  - RD_WAIT with TX idle (earliest N+2): TX shift register <= rdata and read_ack=1 for that cycle; go to CMD.
  - RD_WAIT with TX busy: stay in RD_WAIT until TX is idle, then capture as above.
  - Any rx_valid while in RD_WAIT is dropped. addr must not change while a read is pending.
- TX path:
  - Starts on the cycle after capture.
  - Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly DIV cycles, so a frame is 10*DIV cycles.
  - TX is busy until the end of the stop bit. uart_txd=1 whenever idle.
- write and read_ack never assert in the same cycle. write is never asserted without a preceding valid command byte.
- RX and TX are independent. A full-duplex overlap of an incoming byte with an outgoing frame is legal.

Test Plan:
Bench setting: UART_CLK_FREQ=16, UART_BAUD=1, so DIV=16.
- Write: send 0xA1 then 0x5C. Required: addr=0x21 from N+1 of the first byte; write=1 for exactly one cycle at N+1 of the second byte with wdata=0x5C; read_ack stays 0.
- Read: send 0x40 with rdata tied to 0x3C. Required: addr=0x40; read_ack pulses once at N+2; uart_txd shows start bit, then 0,0,1,1,1,1,0,0, then stop bit, each 16 cycles.
- Back-to-back reads: send 0x41 immediately after 0x40. Required: the second read waits in RD_WAIT until the first TX stop bit ends; two complete frames with no gap shorter than 0 idle cycles; addr=0x41 only after the 0x41 byte is received.
- Glitch and framing error:
  - A 5-cycle low pulse on uart_rxd produces no byte.
  - 0xA2 followed by a data byte with stop bit 0 produces no write, and the FSM returns to CMD.
  - A following 0x30 read is then handled normally.
- Reset mid-operation: assert n_reset during TX bit 4. Required: uart_txd=1 asynchronously and all outputs at reset values. After release, a fresh 0xA0 0x01 write works.
